// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU issue shared types, opSel codes, opcodes and funct3 mapping
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int OPSEL_W = 5;

    localparam logic [OPSEL_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [OPSEL_W-1:0] ALU_SUB  = 5'd1;
    localparam logic [OPSEL_W-1:0] ALU_SLL  = 5'd2;
    localparam logic [OPSEL_W-1:0] ALU_SLT  = 5'd3;
    localparam logic [OPSEL_W-1:0] ALU_SLTU = 5'd4;
    localparam logic [OPSEL_W-1:0] ALU_XOR  = 5'd5;
    localparam logic [OPSEL_W-1:0] ALU_SRL  = 5'd6;
    localparam logic [OPSEL_W-1:0] ALU_SRA  = 5'd7;
    localparam logic [OPSEL_W-1:0] ALU_OR   = 5'd8;
    localparam logic [OPSEL_W-1:0] ALU_AND  = 5'd9;
    localparam logic [OPSEL_W-1:0] ALU_NOP  = 5'd10;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [OPSEL_W-1:0] opSel;
        logic [XLEN-1:0]    op1;
        logic [XLEN-1:0]    op2;
        logic [4:0]         rd;
        logic               rd_we;
        logic               illegal;
    } alu_issue_t;

    function automatic logic [OPSEL_W-1:0] f3_to_opsel(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - combinational RV32I ALU-class decode and operand select
module alu_decode
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output alu_issue_t      dec
);

    logic [6:0]         opcode;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic               legal;
    logic [OPSEL_W-1:0] sel;
    logic [XLEN-1:0]    a;
    logic [XLEN-1:0]    b;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    always_comb begin
        legal = 1'b0;
        sel   = ALU_NOP;
        a     = '0;
        b     = '0;
        case (opcode)
            OPC_OP: begin
                a = rs1;
                b = rs2;
                if (f7 == F7_BASE) begin
                    legal = 1'b1;
                    sel   = f3_to_opsel(f3);
                end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
                    legal = 1'b1;
                    sel   = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
                end
            end
            OPC_OPIMM: begin
                a = rs1;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    b = {27'b0, instr[24:20]};
                    if (f7 == F7_BASE) begin
                        legal = 1'b1;
                        sel   = f3_to_opsel(f3);
                    end else if (f7 == F7_ALT && f3 == 3'b101) begin
                        legal = 1'b1;
                        sel   = ALU_SRA;
                    end
                end else begin
                    legal = 1'b1;
                    sel   = f3_to_opsel(f3);
                    b     = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OPC_LUI: begin
                legal = 1'b1;
                sel   = ALU_ADD;
                b     = {instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                sel   = ALU_ADD;
                a     = pc;
                b     = {instr[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase
        // Illegal entries still issue, but carry no operands into execute.
        if (!legal || instr[1:0] != 2'b11) begin
            legal = 1'b0;
            sel   = ALU_NOP;
            a     = '0;
            b     = '0;
        end
    end

    always_comb begin
        dec         = '0;
        dec.opSel   = sel;
        dec.op1     = a;
        dec.op2     = b;
        dec.rd      = instr[11:7];
        dec.rd_we   = legal && (instr[11:7] != 5'd0);
        dec.illegal = !legal;
    end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - ALU issue stage with 2-entry skid buffer; optional counters via ALU_ISSUE_STATS_EN
module alu_issue
    import alu_pkg::*;
#(
    parameter int XLEN    = alu_pkg::XLEN,
    parameter int OPSEL_W = alu_pkg::OPSEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_instr,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    in_rs1,
    input  logic [XLEN-1:0]    in_rs2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPSEL_W-1:0] opSel,
    output logic [XLEN-1:0]    op1,
    output logic [XLEN-1:0]    op2,
    output logic [4:0]         rd,
    output logic               rd_we,
    output logic               illegal
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0]        stat_issued,
    output logic [31:0]        stat_illegal
`endif
);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} buf_state_t;

    buf_state_t state, state_nxt;
    alu_issue_t dec, main_q, skid_q;
    logic       accept, pop;
    logic       load_main_dec, load_skid, load_main_skid;

    alu_decode u_decode (
        .instr (in_instr),
        .pc    (in_pc),
        .rs1   (in_rs1),
        .rs2   (in_rs2),
        .dec   (dec)
    );

    assign in_ready  = (state != S_FULL);
    assign out_valid = (state != S_EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_nxt      = state;
        load_main_dec  = 1'b0;
        load_skid      = 1'b0;
        load_main_skid = 1'b0;
        case (state)
            S_EMPTY: if (accept) begin
                state_nxt     = S_ONE;
                load_main_dec = 1'b1;
            end
            S_ONE: begin
                if (accept && pop) begin
                    load_main_dec = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = S_FULL;
                end else if (pop) begin
                    state_nxt = S_EMPTY;
                end
            end
            S_FULL: if (pop) begin
                load_main_skid = 1'b1;
                state_nxt      = S_ONE;
            end
            default: state_nxt = S_EMPTY;
        endcase
        // Flush overrides any transfer; stale register contents are hidden by out_valid.
        if (flush) begin
            state_nxt = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nxt;
            if (load_main_dec) begin
                main_q <= dec;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    assign opSel   = main_q.opSel;
    assign op1     = main_q.op1;
    assign op2     = main_q.op2;
    assign rd      = main_q.rd;
    assign rd_we   = main_q.rd_we;
    assign illegal = main_q.illegal;

`ifdef ALU_ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued  <= '0;
            stat_illegal <= '0;
        end else if (pop) begin
            stat_issued <= stat_issued + 32'd1;
            if (main_q.illegal) begin
                stat_illegal <= stat_illegal + 32'd1;
            end
        end
    end
`endif

endmodule
